// File: rtl/rename_map_table_if.sv
// rtl/rename_map_table_if.sv - rename, retire, recovery-walk and checkpoint signals of the rename map table
// Checkpoint signals exist only when MAPTABLE_CKPT_EN is defined.
interface rename_map_table_if #(
  parameter int ARF_NUM  = 32,
  parameter int PRF_NUM  = 64,
  parameter int RENAME_W = 2,
  parameter int COMMIT_W = 2,
`ifdef MAPTABLE_CKPT_EN
  parameter int WALK_W   = 2,
  parameter int NUM_CKPT = 4
`else
  parameter int WALK_W   = 2
`endif
);
  localparam int ARF_W = $clog2(ARF_NUM);
  localparam int PRF_W = $clog2(PRF_NUM);

  logic [RENAME_W-1:0]       ren_valid;
  logic [RENAME_W-1:0]       ren_rd_we;
  logic [RENAME_W*ARF_W-1:0] ren_rs1;
  logic [RENAME_W*ARF_W-1:0] ren_rs2;
  logic [RENAME_W*ARF_W-1:0] ren_rd;
  logic [RENAME_W*PRF_W-1:0] ren_new_prf;
  logic [RENAME_W*PRF_W-1:0] ren_prs1;
  logic [RENAME_W*PRF_W-1:0] ren_prs2;
  logic [RENAME_W*PRF_W-1:0] ren_pdst_old;
  logic                      ren_ready;
  logic [COMMIT_W-1:0]       cmt_valid;
  logic [COMMIT_W*ARF_W-1:0] cmt_rd;
  logic [COMMIT_W*PRF_W-1:0] cmt_prf;
  logic                      flush_req;
  logic [WALK_W-1:0]         walk_valid;
  logic [WALK_W*ARF_W-1:0]   walk_rd;
  logic [WALK_W*PRF_W-1:0]   walk_prf;
  logic                      walk_done;
  logic [1:0]                state;
`ifdef MAPTABLE_CKPT_EN
  localparam int CKPT_W = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;
  logic                      ckpt_take;
  logic [CKPT_W-1:0]         ckpt_take_id;
  logic                      ckpt_restore;
  logic [CKPT_W-1:0]         ckpt_restore_id;
`endif

  modport master (
    output ren_valid, ren_rd_we, ren_rs1, ren_rs2, ren_rd, ren_new_prf,
    output cmt_valid, cmt_rd, cmt_prf, flush_req,
    output walk_valid, walk_rd, walk_prf, walk_done,
`ifdef MAPTABLE_CKPT_EN
    output ckpt_take, ckpt_take_id, ckpt_restore, ckpt_restore_id,
`endif
    input  ren_prs1, ren_prs2, ren_pdst_old, ren_ready, state
  );

  modport slave (
    input  ren_valid, ren_rd_we, ren_rs1, ren_rs2, ren_rd, ren_new_prf,
    input  cmt_valid, cmt_rd, cmt_prf, flush_req,
    input  walk_valid, walk_rd, walk_prf, walk_done,
`ifdef MAPTABLE_CKPT_EN
    input  ckpt_take, ckpt_take_id, ckpt_restore, ckpt_restore_id,
`endif
    output ren_prs1, ren_prs2, ren_pdst_old, ren_ready, state
  );
endinterface

// File: rtl/rename_map_table.sv
// rtl/rename_map_table.sv - speculative RAT + retirement RRAT with RRAT-restore / walk-replay recovery
// Optional checkpoint snapshot/restore is enabled by defining MAPTABLE_CKPT_EN.
module rename_map_table #(
  parameter int ARF_NUM  = 32,
  parameter int PRF_NUM  = 64,
  parameter int RENAME_W = 2,
  parameter int COMMIT_W = 2,
  parameter int WALK_W   = 2,
  parameter int NUM_CKPT = 4
) (
  input logic               clk,
  input logic               reset_n,
  rename_map_table_if.slave bus
);
  localparam int ARF_W = $clog2(ARF_NUM);
  localparam int PRF_W = $clog2(PRF_NUM);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RESTORE = 2'd1;
  localparam logic [1:0] ST_WALK    = 2'd2;

  if (NUM_CKPT < 1) begin : g_bad_ckpt
    $error("NUM_CKPT must be at least 1");
  end

  logic [1:0]       state_q, state_d;
  logic [PRF_W-1:0] rat_q  [ARF_NUM];
  logic [PRF_W-1:0] rat_d  [ARF_NUM];
  logic [PRF_W-1:0] rrat_q [ARF_NUM];
  logic [PRF_W-1:0] rrat_d [ARF_NUM];
  logic             ckpt_restore_go;
  logic             ren_fire;

  logic [RENAME_W-1:0]       ren_valid, ren_rd_we;
  logic [RENAME_W*ARF_W-1:0] ren_rs1, ren_rs2, ren_rd;
  logic [RENAME_W*PRF_W-1:0] ren_new_prf;
  logic [RENAME_W*PRF_W-1:0] prs1_v, prs2_v, pold_v;

  assign ren_valid   = bus.ren_valid;
  assign ren_rd_we   = bus.ren_rd_we;
  assign ren_rs1     = bus.ren_rs1;
  assign ren_rs2     = bus.ren_rs2;
  assign ren_rd      = bus.ren_rd;
  assign ren_new_prf = bus.ren_new_prf;

`ifdef MAPTABLE_CKPT_EN
  logic [PRF_W-1:0] ckpt_q [NUM_CKPT][ARF_NUM];
  // A checkpoint restore is honoured from IDLE or WALK; a flush always overrides it.
  assign ckpt_restore_go = bus.ckpt_restore & ~bus.flush_req & (state_q != ST_RESTORE);
`else
  assign ckpt_restore_go = 1'b0;
`endif

  assign ren_fire      = (state_q == ST_IDLE) & ~bus.flush_req & ~ckpt_restore_go;
  assign bus.ren_ready = ren_fire;
  assign bus.state     = state_q;

  // Mapping of arch reg a as seen by slot 'slot': youngest older writer in the group, else the RAT.
  function automatic logic [PRF_W-1:0] map_src(input logic [ARF_W-1:0] a, input int slot);
    logic [PRF_W-1:0] p;
    p = (a == '0) ? '0 : rat_q[a];
    for (int j = 0; j < slot; j++) begin
      if (ren_valid[j] && ren_rd_we[j] && (a != '0) && (ren_rd[j*ARF_W +: ARF_W] == a))
        p = ren_new_prf[j*PRF_W +: PRF_W];
    end
    return p;
  endfunction

  always_comb begin
    prs1_v = '0;
    prs2_v = '0;
    pold_v = '0;
    for (int i = 0; i < RENAME_W; i++) begin
      prs1_v[i*PRF_W +: PRF_W] = map_src(ren_rs1[i*ARF_W +: ARF_W], i);
      prs2_v[i*PRF_W +: PRF_W] = map_src(ren_rs2[i*ARF_W +: ARF_W], i);
      pold_v[i*PRF_W +: PRF_W] = map_src(ren_rd[i*ARF_W +: ARF_W], i);
    end
  end

  assign bus.ren_prs1     = prs1_v;
  assign bus.ren_prs2     = prs2_v;
  assign bus.ren_pdst_old = pold_v;

  always_comb begin
    rrat_d = rrat_q;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (bus.cmt_valid[k] && (bus.cmt_rd[k*ARF_W +: ARF_W] != '0))
        rrat_d[bus.cmt_rd[k*ARF_W +: ARF_W]] = bus.cmt_prf[k*PRF_W +: PRF_W];
    end

    rat_d   = rat_q;
    state_d = state_q;
    if (bus.flush_req) begin
      state_d = ST_RESTORE;
    end
`ifdef MAPTABLE_CKPT_EN
    else if (ckpt_restore_go) begin
      rat_d   = ckpt_q[bus.ckpt_restore_id];
      state_d = ST_IDLE;
    end
`endif
    else begin
      case (state_q)
        ST_IDLE: begin
          for (int i = 0; i < RENAME_W; i++) begin
            if (ren_fire && ren_valid[i] && ren_rd_we[i] && (ren_rd[i*ARF_W +: ARF_W] != '0))
              rat_d[ren_rd[i*ARF_W +: ARF_W]] = ren_new_prf[i*PRF_W +: PRF_W];
          end
        end
        ST_RESTORE: begin
          rat_d   = rrat_d;
          state_d = ST_WALK;
        end
        ST_WALK: begin
          for (int w = 0; w < WALK_W; w++) begin
            if (bus.walk_valid[w] && (bus.walk_rd[w*ARF_W +: ARF_W] != '0))
              rat_d[bus.walk_rd[w*ARF_W +: ARF_W]] = bus.walk_prf[w*PRF_W +: PRF_W];
          end
          if (bus.walk_done)
            state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < ARF_NUM; i++) begin
        rat_q[i]  <= PRF_W'(i);
        rrat_q[i] <= PRF_W'(i);
      end
    end else begin
      state_q <= state_d;
      rat_q   <= rat_d;
      rrat_q  <= rrat_d;
    end
  end

`ifdef MAPTABLE_CKPT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CKPT; c++)
        for (int i = 0; i < ARF_NUM; i++)
          ckpt_q[c][i] <= PRF_W'(i);
    end else if (bus.ckpt_take) begin
      ckpt_q[bus.ckpt_take_id] <= rat_d;
    end
  end
`endif
endmodule
